// File: rtl/pifo_multi_queue_bypass_arbiter_pkg.sv
// pifo_pkg: PIFO entry field layout {valid, overflow, rank, addr} and unpack helper.
// Revision: 1.0
`default_nettype none
package pifo_pkg;
  localparam int PIFO_RANK_W = 18;
  localparam int BUF_ADDR_W  = 12;
  localparam int INFO_W      = 2 + PIFO_RANK_W + BUF_ADDR_W;

  typedef struct packed {
    logic                   valid;
    logic                   overflow;
    logic [PIFO_RANK_W-1:0] rank;
    logic [BUF_ADDR_W-1:0]  addr;
  } pifo_info_t;

  function automatic pifo_info_t pifo_unpack(input logic [INFO_W-1:0] raw);
    return pifo_info_t'(raw);
  endfunction
endpackage
`default_nettype wire

// File: rtl/pifo_multi_queue_bypass_arbiter_gpfc_pause_tracker.sv
// gpfc_pause_tracker: one queue's GPFC pause flag, pause rank and expiry timer.
// Revision: 1.0
`default_nettype none
module gpfc_pause_tracker #(
  parameter int PIFO_RANK_WIDTH = 18,
  parameter int PAUSE_TIMEOUT   = 1024
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       pause_set,
  input  logic                       resume,
  input  logic [PIFO_RANK_WIDTH-1:0] pause_rank,
  output logic                       paused,
  output logic [PIFO_RANK_WIDTH-1:0] rank
);
  localparam int TIMER_WIDTH = (PAUSE_TIMEOUT > 1) ? $clog2(PAUSE_TIMEOUT + 1) : 1;
  localparam logic [TIMER_WIDTH-1:0] TIMER_LOAD = TIMER_WIDTH'(PAUSE_TIMEOUT);

  logic [TIMER_WIDTH-1:0] timer;

  // A fresh pause outranks both resume and expiry in the same cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      paused <= 1'b0;
      rank   <= '0;
      timer  <= '0;
    end else if (pause_set) begin
      paused <= 1'b1;
      rank   <= pause_rank;
      timer  <= TIMER_LOAD;
    end else if (resume) begin
      paused <= 1'b0;
      timer  <= '0;
    end else if (paused && (PAUSE_TIMEOUT != 0)) begin
      timer <= timer - 1'b1;
      if (timer == TIMER_WIDTH'(1)) paused <= 1'b0;
    end
  end
endmodule
`default_nettype wire

// File: rtl/pifo_multi_queue_bypass_arbiter.sv
// pifo_multi_queue_bypass_arbiter: per-packet calendar bypass decision for NUM_QUEUES queues sharing one PIFO root.
// Revision: 1.0
`default_nettype none
module pifo_multi_queue_bypass_arbiter
  import pifo_pkg::*;
#(
  parameter int NUM_QUEUES        = 4,
  parameter int QID_WIDTH         = 2,
  parameter int BUFFER_ADDR_WIDTH = 12,
  parameter int PIFO_RANK_WIDTH   = 18,
  parameter int INFO_WIDTH        = 32,
  parameter int PAUSE_TIMEOUT     = 1024,
  parameter int OUTPUT_SYNC       = 1,
  parameter int STAT_WIDTH        = 32
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             s_axis_valid,
  output logic                             s_axis_ready,
  input  logic [QID_WIDTH-1:0]             s_axis_qid,
  input  logic [INFO_WIDTH-1:0]            s_axis_pifo_info,
  input  logic [NUM_QUEUES*INFO_WIDTH-1:0] s_axis_calendar_tops,
  input  logic [NUM_QUEUES-1:0]            s_axis_global_overflow,
  input  logic                             s_axis_gpfc_valid,
  input  logic [QID_WIDTH-1:0]             s_axis_gpfc_qid,
  input  logic                             s_axis_gpfc_resume,
  input  logic [PIFO_RANK_WIDTH-1:0]       s_axis_gpfc_pause_rank,
  output logic                             m_axis_valid,
  input  logic                             m_axis_ready,
  output logic                             m_axis_bypass_en,
  output logic [QID_WIDTH-1:0]             m_axis_qid,
  output logic [INFO_WIDTH-1:0]            m_axis_pifo_info,
  output logic                             m_axis_qid_err,
  input  logic                             stat_clear,
  output logic [STAT_WIDTH-1:0]            stat_total,
  output logic [STAT_WIDTH-1:0]            stat_bypass
);
  logic [NUM_QUEUES-1:0]      paused_vec;
  logic [PIFO_RANK_WIDTH-1:0] pause_rank_vec [NUM_QUEUES];

  for (genvar q = 0; q < NUM_QUEUES; q++) begin : g_pause
    logic hit;
    assign hit = s_axis_gpfc_valid && (s_axis_gpfc_qid == QID_WIDTH'(q));
    gpfc_pause_tracker #(
      .PIFO_RANK_WIDTH (PIFO_RANK_WIDTH),
      .PAUSE_TIMEOUT   (PAUSE_TIMEOUT)
    ) u_tracker (
      .clk        (clk),
      .rstn       (rstn),
      .pause_set  (hit && !s_axis_gpfc_resume),
      .resume     (hit && s_axis_gpfc_resume),
      .pause_rank (s_axis_gpfc_pause_rank),
      .paused     (paused_vec[q]),
      .rank       (pause_rank_vec[q])
    );
  end

  logic                       qid_err;
  logic [INFO_WIDTH-1:0]      top_raw;
  logic                       q_epoch;
  logic                       q_paused;
  logic [PIFO_RANK_WIDTH-1:0] q_rank;
  pifo_info_t                 info;
  pifo_info_t                 top;
  logic                       base;
  logic                       decision;
  logic                       accept;
  logic                       unused_addr_bits;

  // Extra MSB keeps NUM_QUEUES representable when it equals 2**QID_WIDTH.
  assign qid_err = {1'b0, s_axis_qid} >= (QID_WIDTH + 1)'(NUM_QUEUES);

  always_comb begin
    top_raw  = '0;
    q_epoch  = 1'b0;
    q_paused = 1'b0;
    q_rank   = '0;
    for (int q = 0; q < NUM_QUEUES; q++) begin
      if (s_axis_qid == QID_WIDTH'(q)) begin
        top_raw  = s_axis_calendar_tops[q*INFO_WIDTH +: INFO_WIDTH];
        q_epoch  = s_axis_global_overflow[q];
        q_paused = paused_vec[q];
        q_rank   = pause_rank_vec[q];
      end
    end
  end

  assign info = pifo_unpack(s_axis_pifo_info);
  assign top  = pifo_unpack(top_raw);
  assign unused_addr_bits = ^{info.addr, top.addr};

  // Differing epoch bits: the entry is earlier only if it sits in the current epoch.
  assign base = !top.valid ||
                ((info.overflow != top.overflow) ? (info.overflow == q_epoch)
                                                 : (info.rank < top.rank));
  assign decision = info.valid && !qid_err && base && !(q_paused && (info.rank >= q_rank));
  assign accept   = s_axis_valid && s_axis_ready;

  if (OUTPUT_SYNC != 0) begin : g_sync
    assign s_axis_ready = !m_axis_valid || m_axis_ready;
    always_ff @(posedge clk) begin
      if (!rstn) begin
        m_axis_valid     <= 1'b0;
        m_axis_bypass_en <= 1'b0;
        m_axis_qid       <= '0;
        m_axis_pifo_info <= '0;
        m_axis_qid_err   <= 1'b0;
      end else if (s_axis_ready) begin
        m_axis_valid <= s_axis_valid;
        if (s_axis_valid) begin
          m_axis_bypass_en <= decision;
          m_axis_qid       <= s_axis_qid;
          m_axis_pifo_info <= s_axis_pifo_info;
          m_axis_qid_err   <= qid_err;
        end
      end
    end
  end else begin : g_comb
    assign s_axis_ready     = m_axis_ready;
    assign m_axis_valid     = s_axis_valid;
    assign m_axis_bypass_en = decision;
    assign m_axis_qid       = s_axis_qid;
    assign m_axis_pifo_info = s_axis_pifo_info;
    assign m_axis_qid_err   = qid_err;
  end

  always_ff @(posedge clk) begin
    if (!rstn || stat_clear) begin
      stat_total  <= '0;
      stat_bypass <= '0;
    end else if (accept) begin
      if (stat_total != '1) stat_total <= stat_total + 1'b1;
      if (decision && (stat_bypass != '1)) stat_bypass <= stat_bypass + 1'b1;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_pifo_multi_queue_bypass_arbiter.sv
// Directed-vector bench for pifo_multi_queue_bypass_arbiter (4 queues, 3-bit qid, 8-cycle pause timeout).
`default_nettype none
module tb_pifo_multi_queue_bypass_arbiter;
  localparam int NQ = 4;
  localparam int QW = 3;
  localparam int RW = 18;
  localparam int IW = 32;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            s_axis_valid = 1'b0;
  logic            s_axis_ready;
  logic [QW-1:0]   s_axis_qid = '0;
  logic [IW-1:0]   s_axis_pifo_info = '0;
  logic [NQ*IW-1:0] s_axis_calendar_tops = '0;
  logic [NQ-1:0]   s_axis_global_overflow = '0;
  logic            s_axis_gpfc_valid = 1'b0;
  logic [QW-1:0]   s_axis_gpfc_qid = '0;
  logic            s_axis_gpfc_resume = 1'b0;
  logic [RW-1:0]   s_axis_gpfc_pause_rank = '0;
  logic            m_axis_valid;
  logic            m_axis_ready = 1'b1;
  logic            m_axis_bypass_en;
  logic [QW-1:0]   m_axis_qid;
  logic [IW-1:0]   m_axis_pifo_info;
  logic            m_axis_qid_err;
  logic            stat_clear = 1'b0;
  logic [31:0]     stat_total;
  logic [31:0]     stat_bypass;

  int checks = 0;
  int errors = 0;
  int exp_total = 0;
  int exp_byp = 0;

  always #5 clk = ~clk;

  pifo_multi_queue_bypass_arbiter #(
    .NUM_QUEUES(NQ), .QID_WIDTH(QW), .BUFFER_ADDR_WIDTH(12), .PIFO_RANK_WIDTH(RW),
    .INFO_WIDTH(IW), .PAUSE_TIMEOUT(8), .OUTPUT_SYNC(1), .STAT_WIDTH(32)
  ) dut (
    .clk(clk), .rstn(rstn),
    .s_axis_valid(s_axis_valid), .s_axis_ready(s_axis_ready),
    .s_axis_qid(s_axis_qid), .s_axis_pifo_info(s_axis_pifo_info),
    .s_axis_calendar_tops(s_axis_calendar_tops), .s_axis_global_overflow(s_axis_global_overflow),
    .s_axis_gpfc_valid(s_axis_gpfc_valid), .s_axis_gpfc_qid(s_axis_gpfc_qid),
    .s_axis_gpfc_resume(s_axis_gpfc_resume), .s_axis_gpfc_pause_rank(s_axis_gpfc_pause_rank),
    .m_axis_valid(m_axis_valid), .m_axis_ready(m_axis_ready),
    .m_axis_bypass_en(m_axis_bypass_en), .m_axis_qid(m_axis_qid),
    .m_axis_pifo_info(m_axis_pifo_info), .m_axis_qid_err(m_axis_qid_err),
    .stat_clear(stat_clear), .stat_total(stat_total), .stat_bypass(stat_bypass)
  );

  typedef struct {
    logic [QW-1:0] qid;
    logic          iv;
    logic          io;
    logic [RW-1:0] ir;
    logic          tv;
    logic          to;
    logic [RW-1:0] tr;
    logic [NQ-1:0] glob;
    logic          exp_byp;
    logic          exp_err;
  } vec_t;

  vec_t vecs [10];

  function automatic logic [IW-1:0] mk(input logic v, input logic o, input logic [RW-1:0] r);
    logic [11:0] a;
    a = r[11:0] ^ 12'h5A5;
    return {v, o, r, a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drive one request at the falling edge; top of calendar is placed only at the target queue.
  task automatic set_req(input logic [QW-1:0] q, input logic iv, input logic io, input logic [RW-1:0] ir,
                         input logic tv, input logic to, input logic [RW-1:0] tr, input logic [NQ-1:0] glob);
    s_axis_valid           = 1'b1;
    s_axis_qid             = q;
    s_axis_pifo_info       = mk(iv, io, ir);
    s_axis_calendar_tops   = '0;
    if (int'(q) < NQ) s_axis_calendar_tops[int'(q)*IW +: IW] = mk(tv, to, tr);
    s_axis_global_overflow = glob;
  endtask

  task automatic send_chk(input string name, input logic [QW-1:0] q, input logic [RW-1:0] ir,
                          input logic exp_b);
    @(negedge clk);
    set_req(q, 1'b1, 1'b0, ir, 1'b0, 1'b0, '0, '0);
    @(posedge clk);
    #1;
    exp_total++;
    if (exp_b) exp_byp++;
    chk({name, "_valid"}, 64'(m_axis_valid), 64'd1);
    chk(name, 64'(m_axis_bypass_en), 64'(exp_b));
  endtask

  task automatic gpfc(input logic [QW-1:0] q, input logic resume, input logic [RW-1:0] r);
    @(negedge clk);
    s_axis_valid           = 1'b0;
    s_axis_gpfc_valid      = 1'b1;
    s_axis_gpfc_qid        = q;
    s_axis_gpfc_resume     = resume;
    s_axis_gpfc_pause_rank = r;
    @(posedge clk);
    #1;
    s_axis_gpfc_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      s_axis_valid = 1'b0;
    end
  endtask

  initial begin
    logic [IW-1:0] held;
    logic [IW-1:0] next_info;

    vecs[0] = '{3'd2, 1'b1, 1'b0, 18'd100, 1'b0, 1'b0, 18'd0,  4'b0000, 1'b1, 1'b0};
    vecs[1] = '{3'd0, 1'b1, 1'b0, 18'd60,  1'b1, 1'b0, 18'd50, 4'b0000, 1'b0, 1'b0};
    vecs[2] = '{3'd0, 1'b1, 1'b0, 18'd40,  1'b1, 1'b0, 18'd50, 4'b0000, 1'b1, 1'b0};
    vecs[3] = '{3'd0, 1'b1, 1'b1, 18'd60,  1'b1, 1'b0, 18'd50, 4'b0001, 1'b1, 1'b0};
    vecs[4] = '{3'd0, 1'b1, 1'b1, 18'd60,  1'b1, 1'b0, 18'd50, 4'b0000, 1'b0, 1'b0};
    vecs[5] = '{3'd1, 1'b0, 1'b0, 18'd1,   1'b0, 1'b0, 18'd0,  4'b0000, 1'b0, 1'b0};
    vecs[6] = '{3'd5, 1'b1, 1'b0, 18'd1,   1'b0, 1'b0, 18'd0,  4'b0000, 1'b0, 1'b1};
    vecs[7] = '{3'd0, 1'b1, 1'b0, 18'd50,  1'b1, 1'b0, 18'd50, 4'b0000, 1'b0, 1'b0};
    vecs[8] = '{3'd3, 1'b1, 1'b0, 18'd5,   1'b1, 1'b1, 18'd10, 4'b0000, 1'b1, 1'b0};
    vecs[9] = '{3'd4, 1'b1, 1'b0, 18'd2,   1'b0, 1'b0, 18'd0,  4'b1111, 1'b0, 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", 64'(m_axis_valid), 64'd0);
    chk("rst_bypass", 64'(m_axis_bypass_en), 64'd0);
    chk("rst_qid", 64'(m_axis_qid), 64'd0);
    chk("rst_info", 64'(m_axis_pifo_info), 64'd0);
    chk("rst_qid_err", 64'(m_axis_qid_err), 64'd0);
    chk("rst_stat_total", 64'(stat_total), 64'd0);
    chk("rst_stat_bypass", 64'(stat_bypass), 64'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Decision table: 10 back-to-back accepted requests, 4 of them bypass
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      set_req(vecs[i].qid, vecs[i].iv, vecs[i].io, vecs[i].ir,
              vecs[i].tv, vecs[i].to, vecs[i].tr, vecs[i].glob);
      chk($sformatf("v%0d_s_ready", i), 64'(s_axis_ready), 64'd1);
      @(posedge clk);
      #1;
      exp_total++;
      if (vecs[i].exp_byp) exp_byp++;
      chk($sformatf("v%0d_valid", i), 64'(m_axis_valid), 64'd1);
      chk($sformatf("v%0d_bypass", i), 64'(m_axis_bypass_en), 64'(vecs[i].exp_byp));
      chk($sformatf("v%0d_qid", i), 64'(m_axis_qid), 64'(vecs[i].qid));
      chk($sformatf("v%0d_err", i), 64'(m_axis_qid_err), 64'(vecs[i].exp_err));
      chk($sformatf("v%0d_info", i), 64'(m_axis_pifo_info), 64'(mk(vecs[i].iv, vecs[i].io, vecs[i].ir)));
    end
    chk("stat_total_10", 64'(stat_total), 64'd10);
    chk("stat_bypass_4", 64'(stat_bypass), 64'd4);
    idle(1);
    @(posedge clk);
    #1;
    chk("drain_valid", 64'(m_axis_valid), 64'd0);

    // Clear wins over a simultaneous accepted bypass
    @(negedge clk);
    set_req(3'd2, 1'b1, 1'b0, 18'd7, 1'b0, 1'b0, '0, '0);
    stat_clear = 1'b1;
    @(posedge clk);
    #1;
    stat_clear = 1'b0;
    exp_total = 0;
    exp_byp = 0;
    chk("clr_total", 64'(stat_total), 64'd0);
    chk("clr_bypass", 64'(stat_bypass), 64'd0);

    // Pause q1 at rank 200, timeout 8: paused through the 8th edge after the GPFC edge
    gpfc(3'd1, 1'b0, 18'd200);
    send_chk("pause_below_rank", 3'd1, 18'd150, 1'b1);
    for (int k = 2; k <= 9; k++)
      send_chk($sformatf("pause_e%0d", k), 3'd1, 18'd200, (k == 9));
    send_chk("pause_other_q", 3'd0, 18'd500, 1'b1);

    // Explicit resume
    gpfc(3'd2, 1'b0, 18'd0);
    send_chk("pause_q2_rank0", 3'd2, 18'd5, 1'b0);
    gpfc(3'd2, 1'b1, 18'd0);
    send_chk("resume_q2", 3'd2, 18'd5, 1'b1);

    // Out-of-range GPFC qid is ignored
    gpfc(3'd6, 1'b0, 18'd0);
    send_chk("gpfc_bad_qid_q2", 3'd2, 18'd5, 1'b1);

    // GPFC in the accepting cycle only affects the following request
    @(negedge clk);
    set_req(3'd3, 1'b1, 1'b0, 18'd300, 1'b0, 1'b0, '0, '0);
    s_axis_gpfc_valid = 1'b1;
    s_axis_gpfc_qid = 3'd3;
    s_axis_gpfc_resume = 1'b0;
    s_axis_gpfc_pause_rank = 18'd100;
    @(posedge clk);
    #1;
    s_axis_gpfc_valid = 1'b0;
    exp_total++;
    exp_byp++;
    chk("same_cycle_gpfc", 64'(m_axis_bypass_en), 64'd1);
    send_chk("after_gpfc", 3'd3, 18'd300, 1'b0);

    // Backpressure: A held for 5 cycles, then exactly one handoff to B
    idle(1);
    @(negedge clk);
    m_axis_ready = 1'b0;
    set_req(3'd2, 1'b1, 1'b0, 18'd11, 1'b0, 1'b0, '0, '0);
    held = s_axis_pifo_info;
    @(posedge clk);
    #1;
    exp_total++;
    exp_byp++;
    @(negedge clk);
    set_req(3'd2, 1'b1, 1'b0, 18'd22, 1'b0, 1'b0, '0, '0);
    next_info = s_axis_pifo_info;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d_s_ready", c), 64'(s_axis_ready), 64'd0);
      chk($sformatf("bp%0d_hold", c), 64'(m_axis_pifo_info), 64'(held));
      chk($sformatf("bp%0d_valid", c), 64'(m_axis_valid), 64'd1);
    end
    chk("bp_stat_total", 64'(stat_total), 64'(exp_total));
    @(negedge clk);
    m_axis_ready = 1'b1;
    @(posedge clk);
    #1;
    exp_total++;
    exp_byp++;
    chk("bp_next_info", 64'(m_axis_pifo_info), 64'(next_info));
    chk("bp_next_valid", 64'(m_axis_valid), 64'd1);
    idle(1);
    @(posedge clk);
    #1;
    chk("bp_drained", 64'(m_axis_valid), 64'd0);
    chk("stat_total_run", 64'(stat_total), 64'(exp_total));
    chk("stat_bypass_run", 64'(stat_bypass), 64'(exp_byp));

    // Reset while a decision is stalled drops it
    @(negedge clk);
    m_axis_ready = 1'b0;
    set_req(3'd1, 1'b1, 1'b0, 18'd1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    s_axis_valid = 1'b0;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_valid", 64'(m_axis_valid), 64'd0);
    chk("rst_mid_stat", 64'(stat_total), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    m_axis_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_no_replay", 64'(m_axis_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
